// File: rtl/bin_window_buffer_b5.sv
// Binary sliding-window buffer: burst FIFO feeding a KSIZE-deep shift window with
// stride and frame-boundary handling, handed off to the XNOR-popcount conv over valid/ready.
module bin_window_buffer_b5 #(
  parameter int CH     = 32,
  parameter int KSIZE  = 7,
  parameter int STRIDE = 1,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [CH-1:0]              in_data,
  input  logic                       in_last,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [KSIZE*CH-1:0]        win_data,
  output logic                       win_last,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int KW = KSIZE * CH;
  localparam int FW = $clog2(KSIZE + 1);
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  typedef struct packed {
    logic          last;
    logic [CH-1:0] data;
  } ent_t;

  ent_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  ent_t          head;
  logic          pop, push, full;

  logic [KW-1:0] win_sr, shifted;
  logic [FW-1:0] fill, fill_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic          fill_full, emit;

  assign head = mem[rd_ptr];
  assign full = fifo_count == (AW+1)'(DEPTH);
  assign pop  = (fifo_count != '0) && (!win_valid || win_ready);
  // a pop frees a slot this same cycle, so a full FIFO can still take a beat
  assign push = in_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!push && pop) fifo_count <= fifo_count - 1'b1;
      if (in_valid && !push) overflow <= 1'b1;
    end
  end

  assign shifted   = {win_sr[KW-CH-1:0], head.data};
  assign fill_nxt  = (fill == FW'(KSIZE)) ? fill : fill + 1'b1;
  assign fill_full = fill_nxt == FW'(KSIZE);
  assign phase_nxt = (phase == PW'(STRIDE - 1)) ? '0 : phase + 1'b1;
  assign emit      = pop && fill_full && (phase == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      win_sr    <= '0;
      fill      <= '0;
      phase     <= '0;
      win_valid <= 1'b0;
      win_data  <= '0;
      win_last  <= 1'b0;
    end else begin
      if (pop) begin
        // frame end: next frame's windows must never see this frame's vectors
        if (head.last) begin
          win_sr <= '0;
          fill   <= '0;
          phase  <= '0;
        end else begin
          win_sr <= shifted;
          fill   <= fill_nxt;
          if (fill_full) phase <= phase_nxt;
        end
      end
      if (emit) begin
        win_valid <= 1'b1;
        win_data  <= shifted;
        win_last  <= head.last;
      end else if (win_valid && win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bin_window_buffer_b5.sv
// Bench: queue-level model of two instances (stride 1 and stride 2) checked every cycle,
// plus directed literal checks on the accepted-window logs.
module tb_bin_window_buffer_b5;
  localparam int CH = 32, K = 7, DEPTH = 16, KW = K * CH;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, win_ready = 1'b0;
  logic [CH-1:0] in_data = '0;
  logic v0, l0, o0, v1, l1, o1;
  logic [KW-1:0] d0, d1;
  logic [4:0] c0, c1;

  always #5 clk = ~clk;

  bin_window_buffer_b5 #(.CH(CH), .KSIZE(K), .STRIDE(1), .DEPTH(DEPTH)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .win_valid(v0), .win_ready(win_ready), .win_data(d0), .win_last(l0),
    .fifo_count(c0), .overflow(o0));

  bin_window_buffer_b5 #(.CH(CH), .KSIZE(K), .STRIDE(2), .DEPTH(DEPTH)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .win_valid(v1), .win_ready(win_ready), .win_data(d1), .win_last(l1),
    .fifo_count(c1), .overflow(o1));

  typedef logic [CH:0] ent_t;
  typedef logic [KW:0] win_t;

  ent_t          mq0[$], mq1[$];
  logic [CH-1:0] h0[$], h1[$];
  int            nf[2];
  bit            ev[2], el[2], eo[2];
  logic [KW-1:0] ed[2];
  win_t          log0[$], log1[$];
  int tests = 0, fails = 0, cyc = 0, first_v = -1, t0 = 0;

  // window 0..6 of the 1<<i stream: newest (1<<6) at the LSB, oldest (1<<0) at the MSB
  localparam logic [KW-1:0] W0 =
    224'h00000001_00000002_00000004_00000008_00000010_00000020_00000040;

  task automatic chk(input string nm, input logic [KW:0] got, input logic [KW:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // model: frame-relative vector index k emits when k >= K-1 and (k-(K-1)) is a stride multiple
  task automatic step(input int m, input int stride);
    ent_t q[$];
    logic [CH-1:0] h[$];
    ent_t e;
    bit popped, pushed;
    int k;
    if (m == 0) begin q = mq0; h = h0; end else begin q = mq1; h = h1; end
    if (rst) begin
      q.delete(); h.delete();
      nf[m] = 0; ev[m] = 0; el[m] = 0; eo[m] = 0; ed[m] = '0;
    end else begin
      popped = (q.size() != 0) && (!ev[m] || win_ready);
      pushed = in_valid && (q.size() < DEPTH || popped);
      if (in_valid && !pushed) eo[m] = 1;
      if (ev[m] && win_ready) ev[m] = 0;
      if (popped) begin
        e = q.pop_front();
        h.push_back(e[CH-1:0]);
        if (h.size() > K) void'(h.pop_front());
        k = nf[m];
        nf[m]++;
        if (k >= K - 1 && ((k - (K - 1)) % stride) == 0) begin
          ev[m] = 1;
          el[m] = e[CH];
          for (int j = 0; j < K; j++) ed[m][j*CH +: CH] = h[h.size()-1-j];
        end
        if (e[CH]) begin h.delete(); nf[m] = 0; end
      end
      if (pushed) q.push_back({in_last, in_data});
    end
    if (m == 0) begin mq0 = q; h0 = h; end else begin mq1 = q; h1 = h; end
  endtask

  always @(posedge clk) begin
    if (!rst && v0 && win_ready) log0.push_back({l0, d0});
    if (!rst && v1 && win_ready) log1.push_back({l1, d1});
    step(0, 1);
    step(1, 2);
    cyc++;
  end

  always @(negedge clk) begin
    chk("s1_valid", KW'(v0), KW'(ev[0]));
    chk("s1_count", KW'(c0), KW'(mq0.size()));
    chk("s1_ovf",   KW'(o0), KW'(eo[0]));
    if (ev[0]) begin
      chk("s1_data", {1'b0, d0}, {1'b0, ed[0]});
      chk("s1_last", KW'(l0), KW'(el[0]));
    end
    chk("s2_valid", KW'(v1), KW'(ev[1]));
    chk("s2_count", KW'(c1), KW'(mq1.size()));
    chk("s2_ovf",   KW'(o1), KW'(eo[1]));
    if (ev[1]) begin
      chk("s2_data", {1'b0, d1}, {1'b0, ed[1]});
      chk("s2_last", KW'(l1), KW'(el[1]));
    end
    if (v0 && first_v < 0) first_v = cyc;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    log0.delete(); log1.delete(); first_v = -1;
  endtask

  task automatic beat(input logic [CH-1:0] d, input logic l);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    win_t w;
    repeat (2) @(negedge clk);
    chk("rst_valid", KW'(v0), '0);
    chk("rst_data",  {1'b0, d0}, '0);
    chk("rst_count", KW'(c0), '0);
    chk("rst_ovf",   KW'(o0), '0);
    rst = 1'b0;

    // stride 1 / stride 2 streaming
    do_reset();
    win_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      beat(CH'(1) << i, i == 15);
      if (i == 0) t0 = cyc;
    end
    idle(20);
    chk("t1_latency", KW'(first_v - t0), KW'(8));
    chk("t1_nwin", KW'(log0.size()), KW'(10));
    if (log0.size() == 10) begin
      chk("t1_win0", log0[0], {1'b0, W0});
      w = log0[9];
      chk("t1_last9", KW'(w[KW]), KW'(1));
      w = log0[8];
      chk("t1_last8", KW'(w[KW]), KW'(0));
    end
    chk("t2_nwin", KW'(log1.size()), KW'(5));
    for (int k = 0; k < log1.size(); k++) begin
      w = log1[k];
      chk("t2_newest", KW'(w[CH-1:0]), KW'(CH'(1) << (6 + 2*k)));
      chk("t2_last", KW'(w[KW]), KW'(0));
    end

    // backpressure and overflow
    do_reset();
    win_ready = 1'b0;
    for (int i = 0; i < 30; i++) beat(CH'(1) << i, 1'b0);
    idle(3);
    chk("t3_valid", KW'(v0), KW'(1));
    chk("t3_held",  {1'b0, d0}, {1'b0, W0});
    chk("t3_count", KW'(c0), KW'(16));
    chk("t3_ovf",   KW'(o0), KW'(1));
    win_ready = 1'b1;
    idle(25);
    chk("t3_nwin", KW'(log0.size()), KW'(17));
    for (int k = 0; k < log0.size(); k++) begin
      w = log0[k];
      chk("t3_newest", KW'(w[CH-1:0]), KW'(CH'(1) << (6 + k)));
      chk("t3_oldest", KW'(w[KW-1 -: CH]), KW'(CH'(1) << k));
    end

    // frame isolation
    do_reset();
    win_ready = 1'b1;
    for (int i = 0; i < 9; i++) beat('1, i == 8);
    for (int i = 0; i < 7; i++) beat('0, i == 6);
    idle(20);
    chk("t4_nwin", KW'(log0.size()), KW'(4));
    if (log0.size() == 4) begin
      chk("t4_a0", log0[0], {1'b0, {KW{1'b1}}});
      chk("t4_a2", log0[2], {1'b1, {KW{1'b1}}});
      chk("t4_b0", log0[3], {1'b1, {KW{1'b0}}});
    end

    // short frame then a full frame
    do_reset();
    win_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(CH'(1) << (20 + i), i == 3);
    idle(10);
    chk("t5_short", KW'(log0.size()), KW'(0));
    for (int i = 0; i < 7; i++) beat(CH'(1) << i, i == 6);
    idle(12);
    chk("t5_nwin", KW'(log0.size()), KW'(1));
    if (log0.size() == 1) chk("t5_win", log0[0], {1'b1, W0});

    // reset mid-stall
    do_reset();
    win_ready = 1'b0;
    for (int i = 0; i < 30; i++) beat(CH'(1) << i, 1'b0);
    idle(3);
    win_ready = 1'b1;
    repeat (11) @(negedge clk);
    win_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_pre_valid", KW'(v0), KW'(1));
    chk("t6_pre_count", KW'(c0), KW'(5));
    chk("t6_pre_ovf",   KW'(o0), KW'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    log0.delete(); log1.delete(); first_v = -1;
    chk("t6_valid", KW'(v0), '0);
    chk("t6_data",  {1'b0, d0}, '0);
    chk("t6_last",  KW'(l0), '0);
    chk("t6_count", KW'(c0), '0);
    chk("t6_ovf",   KW'(o0), '0);
    win_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      beat(CH'(1) << i, i == 6);
      if (i == 0) t0 = cyc;
    end
    idle(15);
    chk("t6_latency", KW'(first_v - t0), KW'(8));
    chk("t6_nwin", KW'(log0.size()), KW'(1));
    if (log0.size() == 1) chk("t6_win", log0[0], {1'b1, W0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
